// File: rtl/connect4_win_checker_if.sv
// rtl/connect4_win_checker_if.sv - start/board/result bundle between move commit, win checker and game FSM.
// Optional win_cells member is present only when CONNECT4_WIN_MASK_EN is defined.
interface connect4_win_checker_if;
   logic        start;
   logic [15:0] gameboard;
   logic [15:0] players_cells;
   logic        busy;
   logic        done;
   logic [1:0]  result;
   logic        game_over;
`ifdef CONNECT4_WIN_MASK_EN
   logic [15:0] win_cells;

   modport master (
      output start, gameboard, players_cells,
      input  busy, done, result, game_over, win_cells
   );
   modport slave (
      input  start, gameboard, players_cells,
      output busy, done, result, game_over, win_cells
   );
`else
   modport master (
      output start, gameboard, players_cells,
      input  busy, done, result, game_over
   );
   modport slave (
      input  start, gameboard, players_cells,
      output busy, done, result, game_over
   );
`endif
endinterface

// File: rtl/connect4_win_checker.sv
// rtl/connect4_win_checker.sv - 4x4 board line scanner reporting a 4-in-a-line win or draw, one line per clock.
// Optional winning-line mask output is enabled by defining CONNECT4_WIN_MASK_EN.
module connect4_win_checker #(
   parameter bit STICKY_RESULT = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   connect4_win_checker_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   state_t      state_q, state_d;
   logic [3:0]  line_idx_q, line_idx_d;
   logic [15:0] board_q, board_d;
   logic [15:0] owner_q, owner_d;
   logic        done_q, done_d;
   logic [1:0]  result_q, result_d;
   logic        game_over_q, game_over_d;
   logic [15:0] win_cells_q, win_cells_d;

   logic [15:0] line_mask;
   logic        line_full;
   logic        line_p1;
   logic        line_p2;

   // Rows bottom-up, then columns, then the two diagonals.
   function automatic logic [15:0] mask_of(input logic [3:0] idx);
      case (idx)
         4'd0:    mask_of = 16'h000F;
         4'd1:    mask_of = 16'h00F0;
         4'd2:    mask_of = 16'h0F00;
         4'd3:    mask_of = 16'hF000;
         4'd4:    mask_of = 16'h1111;
         4'd5:    mask_of = 16'h2222;
         4'd6:    mask_of = 16'h4444;
         4'd7:    mask_of = 16'h8888;
         4'd8:    mask_of = 16'h8421;
         4'd9:    mask_of = 16'h1248;
         default: mask_of = 16'h0000;
      endcase
   endfunction

   always_comb begin
      line_mask = mask_of(line_idx_q);
      line_full = ((board_q & line_mask) == line_mask);
      line_p1   = line_full && ((owner_q & line_mask) == 16'h0000);
      line_p2   = line_full && ((owner_q & line_mask) == line_mask);
   end

   always_comb begin
      state_d     = state_q;
      line_idx_d  = line_idx_q;
      board_d     = board_q;
      owner_d     = owner_q;
      done_d      = 1'b0;
      result_d    = result_q;
      game_over_d = game_over_q;
      win_cells_d = win_cells_q;

      case (state_q)
         IDLE: begin
            if (!STICKY_RESULT) begin
               result_d    = RES_NONE;
               game_over_d = 1'b0;
               win_cells_d = 16'h0000;
            end
            if (bus.start) begin
               board_d     = bus.gameboard;
               owner_d     = bus.players_cells;
               line_idx_d  = 4'd0;
               result_d    = RES_NONE;
               game_over_d = 1'b0;
               win_cells_d = 16'h0000;
               state_d     = SCAN;
            end
         end
         SCAN: begin
            if (line_p1 || line_p2) begin
               result_d    = line_p2 ? RES_P2 : RES_P1;
               game_over_d = 1'b1;
               win_cells_d = line_mask;
               done_d      = 1'b1;
               state_d     = REPORT;
            end else if (line_idx_q == 4'd9) begin
               result_d    = (board_q == 16'hFFFF) ? RES_DRAW : RES_NONE;
               game_over_d = (board_q == 16'hFFFF);
               win_cells_d = 16'h0000;
               done_d      = 1'b1;
               state_d     = REPORT;
            end else begin
               line_idx_d  = line_idx_q + 4'd1;
            end
         end
         REPORT: begin
            // Non-sticky results live only for the cycle done is high.
            if (!STICKY_RESULT) begin
               result_d    = RES_NONE;
               game_over_d = 1'b0;
               win_cells_d = 16'h0000;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         line_idx_q  <= 4'd0;
         board_q     <= 16'h0000;
         owner_q     <= 16'h0000;
         done_q      <= 1'b0;
         result_q    <= RES_NONE;
         game_over_q <= 1'b0;
         win_cells_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         line_idx_q  <= line_idx_d;
         board_q     <= board_d;
         owner_q     <= owner_d;
         done_q      <= done_d;
         result_q    <= result_d;
         game_over_q <= game_over_d;
         win_cells_q <= win_cells_d;
      end
   end

   assign bus.busy      = (state_q == SCAN);
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.game_over = game_over_q;
`ifdef CONNECT4_WIN_MASK_EN
   assign bus.win_cells = win_cells_q;
`else
   logic unused_win_cells;
   assign unused_win_cells = ^win_cells_q;
`endif

endmodule

// File: tb/tb_connect4_win_checker.sv
// tb/tb_connect4_win_checker.sv - directed bench for connect4_win_checker, sticky and non-sticky instances.
// Win-mask checks are compiled in when CONNECT4_WIN_MASK_EN is defined.
`timescale 1ns/1ps
module tb_connect4_win_checker;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   connect4_win_checker_if bus ();
   connect4_win_checker_if bus_ns ();

   assign bus_ns.start         = bus.start;
   assign bus_ns.gameboard     = bus.gameboard;
   assign bus_ns.players_cells = bus.players_cells;

   connect4_win_checker #(.STICKY_RESULT(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   connect4_win_checker #(.STICKY_RESULT(1'b0)) dut_ns (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_ns.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`define CHK(tag, obs, exp) \
   begin \
      vectors++; \
      assert ((obs) === (exp)) else begin \
         miscompares++; \
         $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
      end \
   end

   task automatic pulse_start(input logic [15:0] gb, input logic [15:0] pc);
      bus.gameboard     = gb;
      bus.players_cells = pc;
      bus.start         = 1'b1;
      @(posedge clk);
      #1;
      bus.start         = 1'b0;
   endtask

   task automatic wait_done(output int edge_n, output int busy_n);
      edge_n = -1;
      busy_n = bus.busy ? 1 : 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            edge_n = i;
            break;
         end
         if (bus.busy) busy_n++;
      end
      vectors++;
      if (edge_n < 0) begin
         miscompares++;
         $error("FAIL wait_done expired: no done pulse within 20 edges");
      end
   endtask

   task automatic check_reset_state(input string tag);
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.result !== 2'b00 || bus.game_over !== 1'b0 ||
          bus_ns.busy !== 1'b0 || bus_ns.done !== 1'b0 ||
          bus_ns.result !== 2'b00 || bus_ns.game_over !== 1'b0) begin
         miscompares++;
         $error("FAIL %s: outputs not at reset values busy=%0b done=%0b result=%0h game_over=%0b",
                tag, bus.busy, bus.done, bus.result, bus.game_over);
      end
   endtask

   int  n;
   int  bn;
   bit  seen;

   initial begin
      vectors           = 0;
      miscompares       = 0;
      bus.start         = 1'b0;
      bus.gameboard     = 16'h0000;
      bus.players_cells = 16'h0000;
      reset             = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      check_reset_state("reset_state");
      `CHK("reset_busy", bus.busy, 1'b0)
      `CHK("reset_done", bus.done, 1'b0)
      `CHK("reset_result", bus.result, 2'b00)
      `CHK("reset_game_over", bus.game_over, 1'b0)
`ifdef CONNECT4_WIN_MASK_EN
      `CHK("reset_win_cells", bus.win_cells, 16'h0000)
`endif

      pulse_start(16'h000F, 16'h0000);
      wait_done(n, bn);
      `CHK("row0_done_edge", n, 1)
      `CHK("row0_busy_cycles", bn, 1)
      `CHK("row0_result", bus.result, 2'b01)
      `CHK("row0_game_over", bus.game_over, 1'b1)
      `CHK("row0_ns_result", bus_ns.result, 2'b01)
`ifdef CONNECT4_WIN_MASK_EN
      `CHK("row0_win_cells", bus.win_cells, 16'h000F)
`endif
      @(posedge clk);
      #1;
      `CHK("row0_done_drop", bus.done, 1'b0)
      `CHK("row0_sticky_hold", bus.result, 2'b01)
      `CHK("row0_ns_clear", bus_ns.result, 2'b00)
      `CHK("row0_ns_go_clear", bus_ns.game_over, 1'b0)

      pulse_start(16'h4444, 16'h4444);
      wait_done(n, bn);
      `CHK("col2_done_edge", n, 7)
      `CHK("col2_busy_cycles", bn, 7)
      `CHK("col2_result", bus.result, 2'b10)
      `CHK("col2_game_over", bus.game_over, 1'b1)
`ifdef CONNECT4_WIN_MASK_EN
      `CHK("col2_win_cells", bus.win_cells, 16'h4444)
`endif
      @(posedge clk);
      #1;
      `CHK("col2_busy_after", bus.busy, 1'b0)

      pulse_start(16'h1248, 16'h0000);
      wait_done(n, bn);
      `CHK("anti_done_edge", n, 10)
      `CHK("anti_result", bus.result, 2'b01)
`ifdef CONNECT4_WIN_MASK_EN
      `CHK("anti_win_cells", bus.win_cells, 16'h1248)
`endif
      @(posedge clk);
      #1;

      pulse_start(16'hFFFF, 16'h3C3C);
      wait_done(n, bn);
      `CHK("draw_done_edge", n, 10)
      `CHK("draw_result", bus.result, 2'b11)
      `CHK("draw_game_over", bus.game_over, 1'b1)
`ifdef CONNECT4_WIN_MASK_EN
      `CHK("draw_win_cells", bus.win_cells, 16'h0000)
`endif
      @(posedge clk);
      #1;

      pulse_start(16'h000F, 16'h0001);
      wait_done(n, bn);
      `CHK("mixed_done_edge", n, 10)
      `CHK("mixed_result", bus.result, 2'b00)
      `CHK("mixed_game_over", bus.game_over, 1'b0)
      @(posedge clk);
      #1;

      pulse_start(16'h000F, 16'h0001);
      seen = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) seen = 1'b1;
      end
      `CHK("rst_busy_before", bus.busy, 1'b1)
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      `CHK("rst_no_done_seen", seen, 1'b0)
      check_reset_state("rst_mid_scan_state");
      `CHK("rst_busy", bus.busy, 1'b0)
      `CHK("rst_done", bus.done, 1'b0)
      `CHK("rst_result", bus.result, 2'b00)
      `CHK("rst_game_over", bus.game_over, 1'b0)
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) seen = 1'b1;
      end
      `CHK("rst_stays_idle", seen, 1'b0)

      pulse_start(16'h4444, 16'h4444);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.gameboard     = 16'h000F;
      bus.players_cells = 16'h0000;
      bus.start         = 1'b1;
      @(posedge clk);
      #1;
      bus.start         = 1'b0;
      n = -1;
      for (int i = 4; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            n = i;
            break;
         end
      end
      vectors++;
      if (n < 0) begin
         miscompares++;
         $error("FAIL ignore_wait expired: no done pulse within 20 edges");
      end
      `CHK("ignore_done_edge", n, 7)
      `CHK("ignore_result", bus.result, 2'b10)
      `CHK("ignore_ns_result", bus_ns.result, 2'b10)
      `CHK("ignore_ns_done", bus_ns.done, 1'b1)
      @(posedge clk);
      #1;
      `CHK("ignore_ns_clear", bus_ns.result, 2'b00)
      `CHK("ignore_sticky_hold", bus.result, 2'b10)
`ifdef CONNECT4_WIN_MASK_EN
      `CHK("ignore_ns_win_clear", bus_ns.win_cells, 16'h0000)
      `CHK("ignore_sticky_win", bus.win_cells, 16'h4444)
`endif
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) seen = 1'b1;
      end
      `CHK("ignore_no_queue", seen, 1'b0)

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares != 0)
         $error("FAIL summary: %0d miscompares", miscompares);
      $finish;
   end

endmodule
